// File: rtl/mips_bus_ram_responder.sv
// Responder end of the MIPS CPU memory bus: fixed-stall waitrequest handshake over a byte-enabled word RAM.
// Defining RAM_RANDOM_WAIT_EN adds 0-3 LFSR-chosen extra stall cycles per accepted access.
module mips_bus_ram_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW = 5;
  localparam logic [32:0] SPAN = 33'(64'(MEM_WORDS) * 64'd4);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   mem [MEM_WORDS];

  // Access captured at accept; stall-time input changes are ignored.
  logic [AW-1:0] lat_idx;
  logic          lat_in_range;
  logic          lat_write;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  logic [31:0]   offset_c;
  logic          in_range_c;
  logic [AW-1:0] index_c;
  logic          accept_c, clash_c, abort_c;
  logic          enter_ack_c, complete_c;
  logic [CW-1:0] extra_c, load_c;
  logic [AW-1:0] acc_idx_c;
  logic          acc_in_range_c, acc_write_c;
  logic          unused_c;

  // Address decode relative to BASE_ADDR; lanes [1:0] are ignored.
  assign offset_c   = address - BASE_ADDR;
  assign in_range_c = (address >= BASE_ADDR) && ({1'b0, offset_c} < SPAN);
  assign index_c    = offset_c[AW+1:2];
  assign unused_c   = &{1'b0, offset_c};

  assign accept_c = (state == IDLE) && (read ^ write);
  assign clash_c  = (state == IDLE) && read && write;
  assign abort_c  = !read && !write;
  assign load_c   = WAIT_LOAD + extra_c;

  // When entering ACK straight from IDLE the latches are not loaded yet.
  assign acc_idx_c      = (state == IDLE) ? index_c : lat_idx;
  assign acc_in_range_c = (state == IDLE) ? in_range_c : lat_in_range;
  assign acc_write_c    = (state == IDLE) ? write : lat_write;

`ifdef RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, advanced once per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else if (accept_c) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra_c = CW'(lfsr[1:0]);
`else
  assign extra_c = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    waitrequest = 1'b1;
    enter_ack_c = 1'b0;
    complete_c  = 1'b0;
    case (state)
      IDLE: begin
        waitrequest = read | write;
        if (accept_c) begin
          cnt_nxt = load_c;
          if (load_c == '0) begin
            state_nxt   = ACK;
            enter_ack_c = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort_c) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= CW'(1)) begin
          state_nxt   = ACK;
          cnt_nxt     = '0;
          enter_ack_c = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK: begin
        waitrequest = 1'b0;
        state_nxt   = IDLE;
        complete_c  = !abort_c;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      lat_idx      <= index_c;
      lat_in_range <= in_range_c;
      lat_write    <= write;
      lat_wdata    <= writedata;
      lat_be       <= byteenable;
    end
  end

  // readdata is loaded on the edge into ACK; error is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      error    <= 1'b0;
    end else begin
      if (enter_ack_c && !acc_write_c) begin
        readdata <= acc_in_range_c ? mem[acc_idx_c] : 32'h0000_0000;
      end
      if (clash_c || (complete_c && !lat_in_range)) begin
        error <= 1'b1;
      end
    end
  end

  // RAM is never cleared; writes commit lane-by-lane on the completing edge.
  always_ff @(posedge clk) begin
    if (!reset && complete_c && lat_write && lat_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
